// File: rtl/sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module  : sprite_line_engine
// Brief   : Per-scanline multi-sprite renderer into a ping-pong line buffer.
//           Optional mirroring support is built when SPRITE_FLIP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_line_engine #(
    parameter int NUM_SPRITES      = 8,
    parameter int SPRITES_PER_LINE = 4,
    parameter int LINE_W           = 320
) (
    input  logic                           i_Clk,
    input  logic                           reset,
    input  logic                           line_start,
    input  logic [9:0]                     next_row,
    input  logic                           attr_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] attr_idx,
    input  logic                           attr_en,
    input  logic [5:0]                     attr_num,
    input  logic [9:0]                     attr_x,
    input  logic [9:0]                     attr_y,
    input  logic                           attr_hflip,
    input  logic                           attr_vflip,
    output logic [5:0]                     rom_sprite,
    output logic [2:0]                     rom_row,
    output logic [2:0]                     rom_col,
    input  logic [1:0]                     rom_pixel,
    input  logic [9:0]                     rd_column,
    output logic [1:0]                     rd_pixel,
    output logic                           busy,
    output logic                           overflow,
    output logic                           late,
    input  logic                           flags_clr
);

    localparam int IDX_W  = $clog2(NUM_SPRITES);
    localparam int SLOT_W = (SPRITES_PER_LINE > 1) ? $clog2(SPRITES_PER_LINE) : 1;
    localparam int CNT_W  = $clog2(SPRITES_PER_LINE + 1);
    localparam int CLR_W  = $clog2(LINE_W);
    localparam int ADDR_W = $clog2(2 * LINE_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAW  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_nx;

    // Attribute table; only the x position in buffer-entry units is kept.
    logic [NUM_SPRITES-1:0] en_tab;
    logic [5:0]             num_tab [NUM_SPRITES];
    logic [8:0]             xh_tab  [NUM_SPRITES];
    logic [9:0]             y_tab   [NUM_SPRITES];
    logic                   unused_x0;

    assign unused_x0 = attr_x[0];

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            en_tab <= '0;
        end else if (attr_we) begin
            en_tab[attr_idx] <= attr_en;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (attr_we) begin
            num_tab[attr_idx] <= attr_num;
            xh_tab[attr_idx]  <= attr_x[9:1];
            y_tab[attr_idx]   <= attr_y;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic [NUM_SPRITES-1:0] hf_tab;
    logic [NUM_SPRITES-1:0] vf_tab;

    always_ff @(posedge i_Clk) begin
        if (attr_we) begin
            hf_tab[attr_idx] <= attr_hflip;
            vf_tab[attr_idx] <= attr_vflip;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = attr_hflip ^ attr_vflip;
`endif

    logic              wr_bank;
    logic [9:0]        row_q;
    logic [CLR_W-1:0]  clr_idx;
    logic [IDX_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  nhits;
    logic [CNT_W-1:0]  cur_slot;
    logic [2:0]        col;
    logic              pend;
    logic [9:0]        pend_entry;

    logic [IDX_W-1:0]  slot_idx [SPRITES_PER_LINE];
    logic [2:0]        slot_row [SPRITES_PER_LINE];

    logic [9:0]        scan_dy;
    logic              scan_hit, scan_room, scan_take, scan_last;
    logic [CNT_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]  draw_idx;
    logic [2:0]        draw_row;
    logic [9:0]        draw_entry;

    assign scan_dy   = row_q - y_tab[scan_idx];
    assign scan_hit  = (state == S_SCAN) && en_tab[scan_idx] && (scan_dy < 10'd16);
    assign scan_room = nhits < CNT_W'(SPRITES_PER_LINE);
    assign scan_take = scan_hit && scan_room;
    assign scan_last = scan_idx == IDX_W'(NUM_SPRITES - 1);
    assign scan_cnt  = nhits + CNT_W'(scan_take);

    assign draw_idx   = slot_idx[cur_slot[SLOT_W-1:0]];
    assign draw_row   = slot_row[cur_slot[SLOT_W-1:0]];
    assign draw_entry = {1'b0, xh_tab[draw_idx]} + {7'd0, col};

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        rom_sprite = '0;
        rom_row    = '0;
        rom_col    = '0;
        case (state)
            S_CLEAR: if (clr_idx == CLR_W'(LINE_W - 1)) state_nx = S_SCAN;
            S_SCAN:  if (scan_last) state_nx = (scan_cnt != '0) ? S_DRAW : S_IDLE;
            S_DRAW: begin
                rom_sprite = num_tab[draw_idx];
`ifdef SPRITE_FLIP_EN
                rom_row    = vf_tab[draw_idx] ? ~draw_row : draw_row;
                rom_col    = hf_tab[draw_idx] ? ~col : col;
`else
                rom_row    = draw_row;
                rom_col    = col;
`endif
                if (col == 3'd7 && cur_slot == '0) state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_IDLE;
            default: state_nx = state;
        endcase
        if (line_start) state_nx = S_CLEAR;
    end

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            row_q      <= '0;
            clr_idx    <= '0;
            scan_idx   <= '0;
            nhits      <= '0;
            cur_slot   <= '0;
            col        <= '0;
            pend       <= 1'b0;
            pend_entry <= '0;
        end else begin
            pend       <= (state == S_DRAW) && !line_start;
            pend_entry <= draw_entry;
            if (line_start) begin
                wr_bank  <= ~wr_bank;
                row_q    <= next_row;
                clr_idx  <= '0;
                scan_idx <= '0;
                nhits    <= '0;
                col      <= '0;
            end else begin
                case (state)
                    S_CLEAR: clr_idx <= clr_idx + CLR_W'(1);
                    S_SCAN: begin
                        scan_idx <= scan_idx + IDX_W'(1);
                        nhits    <= scan_cnt;
                        cur_slot <= scan_cnt - CNT_W'(1);
                        col      <= '0;
                    end
                    S_DRAW: begin
                        col <= col + 3'd1;
                        if (col == 3'd7) cur_slot <= cur_slot - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (scan_take && !line_start) begin
            slot_idx[nhits[SLOT_W-1:0]] <= scan_idx;
            slot_row[nhits[SLOT_W-1:0]] <= scan_dy[3:1];
        end
    end

    // Clearing takes priority over a same-cycle set.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            overflow <= 1'b0;
            late     <= 1'b0;
        end else begin
            if (flags_clr)                               overflow <= 1'b0;
            else if (scan_hit && !scan_room && !line_start) overflow <= 1'b1;
            if (flags_clr)                               late <= 1'b0;
            else if (line_start && state != S_IDLE)      late <= 1'b1;
        end
    end

    // Both banks share one array: bank 1 sits at offset LINE_W.
    logic [1:0]        line_mem [2*LINE_W];
    logic              mem_we;
    logic [9:0]        mem_entry;
    logic [1:0]        mem_data;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;

    always_comb begin
        mem_we    = 1'b0;
        mem_entry = pend_entry;
        mem_data  = rom_pixel;
        if (state == S_CLEAR && !line_start) begin
            mem_we    = 1'b1;
            mem_entry = 10'(clr_idx);
            mem_data  = 2'd0;
        end else if (pend && rom_pixel != 2'd0 && pend_entry < 10'(LINE_W)) begin
            mem_we = 1'b1;
        end
    end

    assign mem_waddr = ADDR_W'(mem_entry) + (wr_bank ? ADDR_W'(LINE_W) : ADDR_W'(0));
    assign mem_raddr = ADDR_W'(rd_column[9:1]) + (wr_bank ? ADDR_W'(0) : ADDR_W'(LINE_W));

    always_ff @(posedge i_Clk) begin
        if (mem_we) line_mem[mem_waddr] <= mem_data;
    end

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            rd_pixel <= 2'd0;
        end else if ({1'b0, rd_column} < 11'(2 * LINE_W)) begin
            rd_pixel <= line_mem[mem_raddr];
        end else begin
            rd_pixel <= 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_line_engine
// Brief   : Directed and randomized checks of sprite_line_engine against a
//           line-level painter's-algorithm model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprite_line_engine;

    localparam int N  = 8;
    localparam int S  = 4;
    localparam int LW = 320;

    logic       clk = 1'b0;
    logic       reset, line_start, attr_we, attr_en, attr_hflip, attr_vflip, flags_clr;
    logic [9:0] next_row, attr_x, attr_y, rd_column;
    logic [2:0] attr_idx;
    logic [5:0] attr_num, rom_sprite;
    logic [2:0] rom_row, rom_col;
    logic [1:0] rom_pixel = 2'd0;
    logic [1:0] rd_pixel;
    logic       busy, overflow, late;

    always #5 clk = ~clk;

    sprite_line_engine #(.NUM_SPRITES(N), .SPRITES_PER_LINE(S), .LINE_W(LW)) dut (
        .i_Clk(clk), .reset(reset), .line_start(line_start), .next_row(next_row),
        .attr_we(attr_we), .attr_idx(attr_idx), .attr_en(attr_en), .attr_num(attr_num),
        .attr_x(attr_x), .attr_y(attr_y), .attr_hflip(attr_hflip), .attr_vflip(attr_vflip),
        .rom_sprite(rom_sprite), .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
        .rd_column(rd_column), .rd_pixel(rd_pixel), .busy(busy), .overflow(overflow),
        .late(late), .flags_clr(flags_clr)
    );

    function automatic logic [1:0] rom_fn(int s, int r, int c);
        int h;
        h = s * 37 + r * 11 + c * 13 + 5;
        return 2'((h >> 2) & 3);
    endfunction

    // Sprite ROM with one cycle of read latency.
    always @(posedge clk) rom_pixel <= rom_fn(int'(rom_sprite), int'(rom_row), int'(rom_col));

    int m_en[N], m_num[N], m_x[N], m_y[N], m_hf[N], m_vf[N];
    int exp_cur[LW], exp_prev[LW];
    bit ov_exp, late_exp, had_prev;
    int n_checks, n_fail;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_attr(int idx, int en, int num, int x, int y, int hf, int vf);
        attr_we = 1'b1; attr_idx = 3'(idx); attr_en = 1'(en); attr_num = 6'(num);
        attr_x = 10'(x); attr_y = 10'(y); attr_hflip = 1'(hf); attr_vflip = 1'(vf);
        m_en[idx] = en; m_num[idx] = num; m_x[idx] = x; m_y[idx] = y;
        m_hf[idx] = hf; m_vf[idx] = vf;
        step();
        attr_we = 1'b0;
    endtask

    task automatic clear_attrs();
        for (int i = 0; i < N; i++) set_attr(i, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected buffer for a row: first S hits in index order, painted from
    // the last selected down to index order's first so lower indices win.
    task automatic model_line(int row);
        int hits[$];
        int n, idx, r, rr, cc, e;
        logic [1:0] p;
        for (int i = 0; i < LW; i++) begin
            exp_prev[i] = exp_cur[i];
            exp_cur[i]  = 0;
        end
        for (int i = 0; i < N; i++)
            if (m_en[i] != 0 && ((row - m_y[i]) & 1023) < 16) hits.push_back(i);
        if (hits.size() > S) ov_exp = 1'b1;
        n = (hits.size() > S) ? S : hits.size();
        for (int k = n - 1; k >= 0; k--) begin
            idx = hits[k];
            r = (((row - m_y[idx]) & 1023) >> 1) & 7;
            for (int c = 0; c < 8; c++) begin
`ifdef SPRITE_FLIP_EN
                rr = (m_vf[idx] != 0) ? 7 - r : r;
                cc = (m_hf[idx] != 0) ? 7 - c : c;
`else
                rr = r;
                cc = c;
`endif
                p = rom_fn(m_num[idx], rr, cc);
                e = (m_x[idx] >> 1) + c;
                if (p != 2'd0 && e < LW) exp_cur[e] = int'(p);
            end
        end
    endtask

    task automatic render(int row, string tag);
        int cnt;
        if (busy) late_exp = 1'b1;
        line_start = 1'b1; next_row = 10'(row);
        step();
        line_start = 1'b0;
        model_line(row);
        cnt = 0;
        while (busy && cnt < 900) begin
            step();
            cnt++;
        end
        chk({tag, " busy_fall"}, 32'(busy), 32'd0);
        chk({tag, " line_time"}, 32'(cnt <= LW + N + 8 * S + 3), 32'd1);
        chk({tag, " overflow"}, 32'(overflow), 32'(ov_exp));
        chk({tag, " late"}, 32'(late), 32'(late_exp));
    endtask

    task automatic check_display(string tag);
        for (int c = 0; c < 2 * LW + 4; c++) begin
            rd_column = (c < 2 * LW) ? 10'(c) : 10'(2 * LW + (c - 2 * LW) * 127);
            step();
            chk($sformatf("%s col%0d", tag, rd_column), 32'(rd_pixel),
                (c < 2 * LW) ? 32'(exp_prev[c >> 1]) : 32'd0);
        end
    endtask

    // Renders a row; the line rendered before it is now on display and checked.
    task automatic line(int row, string tag);
        render(row, tag);
        if (had_prev) check_display({tag, " prevline"});
        had_prev = 1'b1;
    endtask

    task automatic clear_flags();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        ov_exp = 1'b0; late_exp = 1'b0;
        chk("flags_clr overflow", 32'(overflow), 32'd0);
        chk("flags_clr late", 32'(late), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int row;
        reset = 1'b1; line_start = 1'b0; next_row = '0; attr_we = 1'b0; attr_idx = '0;
        attr_en = 1'b0; attr_num = '0; attr_x = '0; attr_y = '0; attr_hflip = 1'b0;
        attr_vflip = 1'b0; flags_clr = 1'b0; rd_column = '0;
        n_checks = 0; n_fail = 0; ov_exp = 0; late_exp = 0; had_prev = 0;
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_num[i] = 0; m_x[i] = 0; m_y[i] = 0; m_hf[i] = 0; m_vf[i] = 0;
        end
        for (int i = 0; i < LW; i++) exp_cur[i] = 0;
        repeat (3) step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset late", 32'(late), 32'd0);
        chk("reset rd_pixel", 32'(rd_pixel), 32'd0);
        chk("reset rom", {8'd0, rom_sprite, rom_row, rom_col}, 32'd0);
        reset = 1'b0;
        step();
        chk("post-reset busy", 32'(busy), 32'd0);

        // Single sprite one row below its top edge.
        set_attr(0, 1, 1, 100, 40, 0, 0);
        line(41, "single");

        // Overlap: lower index must win.
        clear_attrs();
        set_attr(0, 1, 5, 200, 10, 0, 0);
        set_attr(3, 1, 9, 200, 10, 0, 0);
        line(10, "overlap");

        // Six hits on one line: only the first four are drawn.
        clear_attrs();
        for (int i = 0; i < 6; i++) set_attr(i, 1, 10 + i, 40 + 12 * i, 45 + i, 0, 0);
        line(50, "overflow");
        clear_flags();

        // Right edge truncation and fully off-screen sprite.
        clear_attrs();
        set_attr(1, 1, 3, 630, 300, 0, 0);
        set_attr(2, 1, 4, 700, 300, 0, 0);
        set_attr(5, 1, 6, 0, 295, 0, 0);
        line(300, "right_edge");

        // Mirrored sprite at dy=0.
        clear_attrs();
        set_attr(0, 1, 7, 64, 200, 1, 1);
        line(200, "flip");

        // Second line_start 100 cycles into a line: abort, then render cleanly.
        line(0, "pre_late");
        clear_attrs();
        set_attr(2, 1, 12, 300, 500, 0, 0);
        set_attr(4, 1, 13, 310, 505, 0, 0);
        line_start = 1'b1; next_row = 10'd500;
        step();
        line_start = 1'b0;
        repeat (99) step();
        had_prev = 1'b0;
        line(507, "late");
        clear_flags();

        for (int it = 0; it < 6; it++) begin
            row = $urandom_range(0, 1023);
            for (int i = 0; i < N; i++)
                set_attr(i, ($urandom % 4) != 0, $urandom % 64, $urandom_range(0, 700),
                         (row - $urandom_range(0, 20)) & 1023, $urandom % 2, $urandom % 2);
            line(row, $sformatf("rand%0d", it));
            clear_flags();
        end

        clear_attrs();
        line(0, "flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Multi-sprite successor to the single-sprite line renderer in the VGA sprite design.
- During each scanline it scans a parametrised sprite attribute table and selects up to SPRITES_PER_LINE sprites that cover the next row.
- It fetches their pixels from the existing 1-cycle-latency sprite ROM and renders them into a ping-pong line buffer.
- The display side reads the opposite bank, so sprites appear exactly one line after they are rendered.

Parameters:
- NUM_SPRITES, 8, entries in the attribute table (power of 2, 2..64).
- SPRITES_PER_LINE, 4, maximum sprites rendered on one line.
- LINE_W, 320, buffer entries per bank; one entry per 2 screen columns.

Ports:
- i_Clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse: swap banks and begin rendering next_row.
- next_row  in  10  row to render; sampled on line_start.
- attr_we  in  1  attribute write strobe.
- attr_idx  in  log2(NUM_SPRITES)  attribute entry written.
- attr_en  in  1  sprite enable.
- attr_num  in  6  sprite ROM index.
- attr_x  in  10  left screen column.
- attr_y  in  10  top screen row.
- attr_hflip  in  1  horizontal mirror (used only with the optional feature).
- attr_vflip  in  1  vertical mirror (used only with the optional feature).
- rom_sprite  out  6  sprite ROM sprite number.
- rom_row  out  3  sprite ROM row.
- rom_col  out  3  sprite ROM column.
- rom_pixel  in  2  sprite ROM data, valid 1 cycle after address.
- rd_column  in  10  display beam column.
- rd_pixel  out  2  display-bank pixel, 1-cycle latency.
- busy  out  1  high whenever the FSM is not in IDLE.
- overflow  out  1  sticky: more than SPRITES_PER_LINE hits on some line.
- late  out  1  sticky: line_start arrived while busy.
- flags_clr  in  1  clears overflow and late.

Behaviour:
- Reset values:
  - FSM IDLE; write bank 0, display bank 1.
  - busy, overflow, late, rd_pixel, rom_* = 0.
  - All attr_en cleared.
  - Buffer RAM contents are not reset.
- Attribute writes are accepted in any cycle. SCAN samples each entry in the cycle it visits it, so a mid-scan write may or may not be seen by the current line.
- line_start: toggle both bank selects, latch next_row, enter CLEAR. If already busy, abort the current line, set late, and restart CLEAR on the new bank.
- CLEAR: write 0 to entries 0..LINE_W-1 of the write bank, one per cycle (LINE_W cycles).
- SCAN: one cycle per entry, index 0..NUM_SPRITES-1.
  - dy = (latched_row - attr_y) mod 1024.
  - Hit when en=1 and dy<16.
  - Hits are stored in ascending index order into slots, with dy[3:1] captured.
  - Any hit beyond SPRITES_PER_LINE sets overflow and is dropped.
- DRAW: slots are processed in descending order, so the lowest attribute index is drawn last and wins overlaps.
  - Per slot, 8 cycles issue rom_col c=0..7, with rom_row = dy[3:1] and rom_sprite = attr_num.
  - One cycle later, entry e = attr_x[9:1] + c is written with rom_pixel only if rom_pixel != 0 (0 = transparent) and e < LINE_W.
  - One drain cycle follows the last slot.
  - Zero hits: DRAW is skipped.
- Return to IDLE; busy falls in that cycle.
- Worst-case line time: LINE_W + NUM_SPRITES + 8*SPRITES_PER_LINE + 3 cycles, which must be ≤ 800 at the default parameters.
- Display read: rd_pixel <= display_bank[rd_column[9:1]]. Returns 0 when rd_column >= 2*LINE_W.
- Sprites with attr_x >= 2*LINE_W draw nothing. There is no negative-x clipping; sprites partly past the right edge are truncated.
- flags_clr takes priority over a same-cycle set: the flag clears.

Optional Feature:
- Macro SPRITE_FLIP_EN.
- Defined: hflip and vflip bits are stored per entry.
  - vflip: rom_row = ~dy[3:1].
  - hflip: rom_col = 7-c, while the write entry remains attr_x[9:1]+c.
- Undefined: attr_hflip and attr_vflip are ignored, no storage is built, and rom_row/rom_col are unmirrored.

Test Plan:
- Reset; sprite 0 with en=1, num=1, x=100, y=40; line_start row=41; next line_start -> rd_column 100..115 returns ROM sprite 1 row 0, busy low within 365 cycles.
- Sprites 0 and 3 both at x=200, y=10, different num; render row 10 -> overlapping opaque pixels come from sprite 0.
- Six sprites enabled on row 50 with SPRITES_PER_LINE=4 -> indices 0..3 rendered, 4..5 absent, overflow=1; flags_clr -> overflow=0.
- Sprite at x=630 -> entries 315..319 written, no write beyond 319; x=700 -> nothing drawn.
- Second line_start 100 cycles after the first -> late=1, and the new bank is cleared and rendered correctly.
- With SPRITE_FLIP_EN, sprite with hflip=1, vflip=1 on dy=0 -> buffer holds ROM row 7 reversed; without the macro -> row 0 unmirrored.
